// File: rtl/sbus_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory between the
// stierlitz sbus (port A) and a local master (port B).
module sbus_arbiter #(
    parameter int ADDR_W  = 40,
    parameter int DATA_W  = 16,
    parameter int MEM_AW  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_pin,
    input  logic              a_start_op,
    input  logic              a_rw,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ready,
    input  logic              b_start_op,
    input  logic              b_rw,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ready,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state, state_nxt;

    logic                     a_pend, b_pend;
    logic                     a_rw_q, b_rw_q;
    logic [ADDR_W-1:0]        a_addr_q, b_addr_q;
    logic [DATA_W-1:0]        a_wdata_q, b_wdata_q;
    logic                     owner;       // 0 = A, 1 = B
    logic                     last_grant;  // 0 = A, 1 = B
    logic [CNT_W-1:0]         cnt;

    logic                     sel_b;
    logic                     own_rw;
    logic [ADDR_W-MEM_AW-1:0] own_hi;
    logic                     oor;
    logic                     done;
    logic [DATA_W-1:0]        rd_val;

    assign a_ready = ~a_pend;
    assign b_ready = ~b_pend;

    // Winner when arbitrating: the lone pending port, else the one not last granted.
    assign sel_b  = b_pend & (~a_pend | ~last_grant);
    assign own_rw = owner ? b_rw_q : a_rw_q;
    assign own_hi = owner ? b_addr_q[ADDR_W-1:MEM_AW] : a_addr_q[ADDR_W-1:MEM_AW];
    assign oor    = |own_hi;
    assign rd_val = (state == WAIT) ? mem_rdata : '0;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_pin) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        grant     = 2'b00;
        case (state)
            IDLE: begin
                if (a_pend || b_pend) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                grant  = {owner, ~owner};
                mem_we = ~own_rw & ~oor;
                mem_re = own_rw & ~oor;
                if (own_rw && !oor) begin
                    state_nxt = WAIT;
                end else begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            WAIT: begin
                grant = {owner, ~owner};
                if (cnt == CNT_W'(MEM_LAT)) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latches, owner/round-robin state, memory address/data and read-back.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_pin) begin
            a_pend     <= 1'b0;
            b_pend     <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if (!a_pend && a_start_op) begin
                a_pend    <= 1'b1;
                a_rw_q    <= a_rw;
                a_addr_q  <= a_address;
                a_wdata_q <= a_wdata;
            end else if (done && !owner) begin
                a_pend <= 1'b0;
            end

            if (!b_pend && b_start_op) begin
                b_pend    <= 1'b1;
                b_rw_q    <= b_rw;
                b_addr_q  <= b_address;
                b_wdata_q <= b_wdata;
            end else if (done && owner) begin
                b_pend <= 1'b0;
            end

            if (state == IDLE && (a_pend || b_pend)) begin
                owner      <= sel_b;
                last_grant <= sel_b;
                mem_addr   <= sel_b ? b_addr_q[MEM_AW-1:0] : a_addr_q[MEM_AW-1:0];
                mem_wdata  <= sel_b ? b_wdata_q : a_wdata_q;
            end

            // cnt holds the number of cycles elapsed since the mem_re cycle.
            if (state == ISSUE) begin
                cnt <= CNT_W'(1);
            end else if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (done && own_rw) begin
                if (owner) begin
                    b_rdata <= rd_val;
                end else begin
                    a_rdata <= rd_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_sbus_arbiter.sv
// Bench for sbus_arbiter: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level timing/memory model.
module tb_sbus_arbiter;

    localparam int ADDR_W  = 40;
    localparam int DATA_W  = 16;
    localparam int MEM_AW  = 16;
    localparam int MEM_LAT = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst_pin = 1'b0;
    logic              a_start_op = 1'b0, a_rw = 1'b0;
    logic [ADDR_W-1:0] a_address = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic [DATA_W-1:0] a_rdata;
    logic              a_ready;
    logic              b_start_op = 1'b0, b_rw = 1'b0;
    logic [ADDR_W-1:0] b_address = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic [DATA_W-1:0] b_rdata;
    logic              b_ready;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we, mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        grant;

    always #5 sys_clk = ~sys_clk;

    sbus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .MEM_LAT(MEM_LAT)) dut (
        .sys_clk(sys_clk), .sys_rst_pin(sys_rst_pin),
        .a_start_op(a_start_op), .a_rw(a_rw), .a_address(a_address), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ready(a_ready),
        .b_start_op(b_start_op), .b_rw(b_rw), .b_address(b_address), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ready(b_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .grant(grant)
    );

    // Single-port memory with MEM_LAT read latency; returns noise when no read is due.
    logic [DATA_W-1:0] sram [0:65535];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];
    logic              rd_vld [MEM_LAT];
    logic [DATA_W-1:0] noise;

    always @(posedge sys_clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        rd_pipe[0] <= sram[mem_addr];
        rd_vld[0]  <= sys_rst_pin & mem_re;
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            rd_vld[i]  <= sys_rst_pin & rd_vld[i-1];
        end
        noise <= 16'($urandom);
    end
    assign mem_rdata = rd_vld[MEM_LAT-1] ? rd_pipe[MEM_LAT-1] : noise;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input int p, input logic st, input logic rw,
                         input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] wd);
        if (p == 0) begin
            a_start_op = st; a_rw = rw; a_address = ad; a_wdata = wd;
        end else begin
            b_start_op = st; b_rw = rw; b_address = ad; b_wdata = wd;
        end
    endtask

    // Leaves the bench in cycle 0: first cycle after reset is released.
    task automatic do_reset();
        sys_rst_pin = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) tick();
        sys_rst_pin = 1'b1;
    endtask

    typedef struct {
        int                port;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              exp_strobe;
        logic [DATA_W-1:0] exp_rdata;
        int                exp_done;
    } vec_t;

    vec_t vecs [9];

    int                done_c, stb_cnt, stb_c, rises, na, nb;
    logic [DATA_W-1:0] stb_addr, stb_wd;
    logic              stb_we, rdy, prev_a, prev_b;
    logic [1:0]        stb_gr;
    logic [DATA_W-1:0] rd;
    logic [1:0]        gq[$];

    // Reference model state for the randomized run
    logic [DATA_W-1:0] ref_mem [0:65535];
    logic              m_pend [2];
    logic              m_sched [2];
    logic              m_rw [2];
    logic [ADDR_W-1:0] m_addr [2];
    logic [DATA_W-1:0] m_wd [2];
    logic [DATA_W-1:0] m_res [2];
    logic [DATA_W-1:0] m_rdata [2];
    int                m_done [2];
    int                m_free, m_iss, m_owner, m_last, w;
    logic              m_iss_we, m_iss_re, m_oor;
    logic [MEM_AW-1:0] m_iss_addr;
    logic [1:0]        exp_gr;
    logic [ADDR_W-1:0] rad;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 1'b0, 40'h00_0000_0010, 16'hBEEF, 1'b1, 16'h0000, 3};
        vecs[1] = '{0, 1'b1, 40'h00_0000_0010, 16'h0000, 1'b1, 16'hBEEF, 5};
        vecs[2] = '{0, 1'b1, 40'h01_0000_0000, 16'h0000, 1'b0, 16'h0000, 3};
        vecs[3] = '{0, 1'b0, 40'h01_0000_0010, 16'h5555, 1'b0, 16'h0000, 3};
        vecs[4] = '{0, 1'b1, 40'h00_0000_0010, 16'h0000, 1'b1, 16'hBEEF, 5};
        vecs[5] = '{1, 1'b0, 40'h00_0000_FFFF, 16'hA5A5, 1'b1, 16'h0000, 3};
        vecs[6] = '{1, 1'b1, 40'h00_0000_FFFF, 16'h0000, 1'b1, 16'hA5A5, 5};
        vecs[7] = '{0, 1'b0, 40'h80_0000_0010, 16'h1111, 1'b0, 16'hBEEF, 3};
        vecs[8] = '{1, 1'b1, 40'h00_0000_0010, 16'h0000, 1'b1, 16'hBEEF, 5};

        do_reset();
        check("rst_a_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_strobes", {mem_we, mem_re}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_grant", grant, 0);

        // Single transactions from an idle arbiter
        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].port, 1'b1, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
            done_c = -1; stb_cnt = 0; stb_c = -1;
            stb_addr = '0; stb_wd = '0; stb_we = 1'b0; stb_gr = 2'b00;
            for (int c = 1; c <= 12 && done_c < 0; c++) begin
                tick();
                drive(vecs[v].port, 1'b0, 1'b0, '0, '0);
                if (mem_we || mem_re) begin
                    stb_cnt++; stb_c = c; stb_addr = mem_addr;
                    stb_we = mem_we; stb_wd = mem_wdata; stb_gr = grant;
                end
                rdy = (vecs[v].port == 0) ? a_ready : b_ready;
                if (rdy) done_c = c;
            end
            rd = (vecs[v].port == 0) ? a_rdata : b_rdata;
            check($sformatf("vec%0d_done_cycle", v), 64'(done_c), 64'(vecs[v].exp_done));
            check($sformatf("vec%0d_strobes", v), 64'(stb_cnt), 64'(vecs[v].exp_strobe));
            check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            if (vecs[v].exp_strobe) begin
                check($sformatf("vec%0d_strobe_cycle", v), 64'(stb_c), 2);
                check($sformatf("vec%0d_mem_addr", v), stb_addr, vecs[v].addr[MEM_AW-1:0]);
                check($sformatf("vec%0d_we", v), stb_we, !vecs[v].rw);
                check($sformatf("vec%0d_grant", v), stb_gr, (vecs[v].port == 0) ? 2'b01 : 2'b10);
                if (!vecs[v].rw) check($sformatf("vec%0d_wdata", v), stb_wd, vecs[v].wdata);
            end
        end

        // Simultaneous start from reset: A write wins the first tie
        do_reset();
        drive(0, 1'b1, 1'b0, 40'h20, 16'h1234);
        drive(1, 1'b1, 1'b1, 40'h20, 16'h0000);
        tick();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        check("sim_c1_ready", {a_ready, b_ready}, 2'b00);
        tick();
        check("sim_c2_we_grant", {mem_we, mem_re, grant}, 4'b1001);
        check("sim_c2_addr", mem_addr, 16'h0020);
        tick();
        check("sim_c3_ready", {a_ready, b_ready}, 2'b10);
        tick();
        check("sim_c4_re_grant", {mem_we, mem_re, grant}, 4'b0110);
        tick();
        tick();
        check("sim_c6_b_ready", b_ready, 0);
        tick();
        check("sim_c7_b_ready", b_ready, 1);
        check("sim_c7_b_rdata", b_rdata, 16'h1234);

        // Extra b_start_op pulses while busy must be ignored
        drive(1, 1'b1, 1'b1, 40'h10, 16'h0000);
        stb_cnt = 0; rises = 0; prev_b = b_ready;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c <= 2) drive(1, 1'b1, 1'b0, 40'h30, 16'h7777);
            else drive(1, 1'b0, 1'b0, '0, '0);
            if (mem_we || mem_re) stb_cnt++;
            if (b_ready && !prev_b) rises++;
            prev_b = b_ready;
        end
        check("ign_strobes", 64'(stb_cnt), 1);
        check("ign_ready_rises", 64'(rises), 1);
        check("ign_b_rdata", b_rdata, 16'hBEEF);

        // Round-robin fairness under continuous re-requests
        do_reset();
        gq.delete();
        na = 0; nb = 0; prev_a = a_ready; prev_b = b_ready;
        drive(0, 1'b1, 1'b0, 40'h40, 16'h0A00);
        drive(1, 1'b1, 1'b0, 40'h41, 16'h0B00);
        for (int c = 1; c <= 200 && (na < 8 || nb < 8); c++) begin
            tick();
            if (mem_we || mem_re) gq.push_back(grant);
            if (a_ready && !prev_a) na++;
            if (b_ready && !prev_b) nb++;
            prev_a = a_ready; prev_b = b_ready;
            drive(0, na < 8, 1'b0, 40'h40, 16'(16'h0A00 + na));
            drive(1, nb < 8, 1'b0, 40'h41, 16'(16'h0B00 + nb));
        end
        check("rr_a_ops", 64'(na), 8);
        check("rr_b_ops", 64'(nb), 8);
        check("rr_strobes", 64'(gq.size()), 16);
        for (int i = 0; i < gq.size(); i++)
            check($sformatf("rr_grant%0d", i), gq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        repeat (4) tick();

        // Reset in the WAIT phase of a read
        drive(0, 1'b1, 1'b1, 40'h20, 16'h0000);
        tick();
        drive(0, 1'b0, 1'b0, '0, '0);
        repeat (4) tick();
        check("mr_pre_a_rdata", a_rdata, 16'h1234);
        drive(0, 1'b1, 1'b1, 40'h10, 16'h0000);
        tick();
        drive(0, 1'b0, 1'b0, '0, '0);
        tick();
        check("mr_c2_re", mem_re, 1);
        tick();
        sys_rst_pin = 1'b0;
        tick();
        sys_rst_pin = 1'b1;
        check("mr_ready", {a_ready, b_ready}, 2'b11);
        check("mr_a_rdata", a_rdata, 0);
        check("mr_grant", grant, 0);
        check("mr_strobes", {mem_we, mem_re}, 0);
        drive(1, 1'b1, 1'b1, 40'h10, 16'h0000);
        tick();
        drive(1, 1'b0, 1'b0, '0, '0);
        check("mr_after_a_rdata", a_rdata, 0);
        check("mr_after_a_ready", a_ready, 1);
        tick();
        check("mr_b_issue", {mem_re, grant}, 3'b110);
        repeat (3) tick();
        check("mr_b_ready", b_ready, 1);
        check("mr_b_rdata", b_rdata, 16'hBEEF);

        // Randomized traffic against the transaction-level model
        do_reset();
        for (int i = 0; i < 65536; i++) ref_mem[i] = sram[i];
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 1'b0; m_sched[p] = 1'b0; m_rdata[p] = '0; m_done[p] = 0;
            m_rw[p] = 1'b0; m_addr[p] = '0; m_wd[p] = '0; m_res[p] = '0;
        end
        m_free = 0; m_iss = 0; m_owner = 0; m_last = 1;
        m_iss_we = 1'b0; m_iss_re = 1'b0; m_iss_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (m_pend[p] && m_sched[p] && m_done[p] == cyc) begin
                    m_pend[p] = 1'b0; m_sched[p] = 1'b0;
                    if (m_rw[p]) m_rdata[p] = m_res[p];
                end
            end
            if (cyc >= m_free && (m_pend[0] || m_pend[1])) begin
                w = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[1] ? 1 : 0);
                m_last = w; m_owner = w; m_sched[w] = 1'b1;
                m_oor = (m_addr[w][ADDR_W-1:MEM_AW] != '0);
                m_iss = cyc + 1;
                m_done[w] = (m_rw[w] && !m_oor) ? cyc + 2 + MEM_LAT : cyc + 2;
                m_free = m_done[w];
                m_iss_we = !m_oor && !m_rw[w];
                m_iss_re = !m_oor && m_rw[w];
                m_iss_addr = m_addr[w][MEM_AW-1:0];
                m_res[w] = m_oor ? '0 : ref_mem[m_iss_addr];
                if (m_iss_we) ref_mem[m_iss_addr] = m_wd[w];
            end
            exp_gr = (cyc >= m_iss && cyc < m_free) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            check("rnd_a_ready", a_ready, !m_pend[0]);
            check("rnd_b_ready", b_ready, !m_pend[1]);
            check("rnd_a_rdata", a_rdata, m_rdata[0]);
            check("rnd_b_rdata", b_rdata, m_rdata[1]);
            check("rnd_grant", grant, exp_gr);
            check("rnd_strobes", {mem_we, mem_re},
                  (cyc == m_iss) ? {m_iss_we, m_iss_re} : 2'b00);
            if (cyc == m_iss && (m_iss_we || m_iss_re)) check("rnd_mem_addr", mem_addr, m_iss_addr);
            for (int p = 0; p < 2; p++) begin
                rad = '0;
                rad[MEM_AW-1:0] = 16'(16'h0F00 + $urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) rad[ADDR_W-1:MEM_AW] = 24'($urandom_range(1, 24'hFFFFFF));
                if (!m_pend[p] && $urandom_range(0, 2) == 0) begin
                    m_pend[p] = 1'b1; m_sched[p] = 1'b0;
                    m_rw[p] = 1'($urandom_range(0, 1));
                    m_addr[p] = rad;
                    m_wd[p] = 16'($urandom);
                    drive(p, 1'b1, m_rw[p], m_addr[p], m_wd[p]);
                end else if (m_pend[p] && $urandom_range(0, 5) == 0) begin
                    drive(p, 1'b1, 1'($urandom_range(0, 1)), rad, 16'($urandom));
                end else begin
                    drive(p, 1'b0, 1'b0, '0, '0);
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
